// File: rtl/ts_pkt_arbiter.sv
// ts_pkt_arbiter: packet-granular round-robin merge of two TS byte sources into one TS FIFO write port.
// Latency: 1 cycle from input handshake to out_wrreq/out_data; one arbitration bubble per packet.
// Backpressure: out_almost_full only blocks new grants; a packet in flight always completes.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   en[1:0]             per-source enable, looked at only while arbitrating (IDLE)
//   inN_data/valid/sop  source N byte stream; inN_ready is high when the byte is taken this cycle
//   out_data/out_wrreq  registered TS FIFO write port
//   out_almost_full     TS FIFO almost full (threshold leaves at least PKT_LEN bytes free)
//   gnt, busy           current/last granted source, high while a packet is being forwarded
//   pkt_cnt0/1          forwarded packets per source (wrapping)
//   sync_err, short_err bad sync bytes drained / packets cut short by an early sop (saturating)
module ts_pkt_arbiter #(
  parameter int         PKT_LEN   = 188,
  parameter logic [7:0] SYNC_BYTE = 8'h47
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  en,
  input  logic [7:0]  in0_data,
  input  logic        in0_valid,
  input  logic        in0_sop,
  output logic        in0_ready,
  input  logic [7:0]  in1_data,
  input  logic        in1_valid,
  input  logic        in1_sop,
  output logic        in1_ready,
  output logic [7:0]  out_data,
  output logic        out_wrreq,
  input  logic        out_almost_full,
  output logic        gnt,
  output logic        busy,
  output logic [15:0] pkt_cnt0,
  output logic [15:0] pkt_cnt1,
  output logic [7:0]  sync_err,
  output logic [7:0]  short_err
);

  localparam int            CW       = $clog2(PKT_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(PKT_LEN - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          last;

  logic       idle;
  logic       good0, good1;
  logic       req0, req1;
  logic       drain0, drain1;
  logic       sop_g, valid_g;
  logic [7:0] data_g;
  logic       early_sop;
  logic       xfer_hs;
  logic       abort_pkt;
  logic [1:0] bad_cnt;
  logic [8:0] sync_sum;
  logic       grant;
  logic       gnt_next;

  assign idle = (state == ST_IDLE);

  // A sop carrying the right sync byte is a packet request; anything else
  // presented while idle is misaligned and gets drained.
  assign good0  = in0_sop & (in0_data == SYNC_BYTE);
  assign good1  = in1_sop & (in1_data == SYNC_BYTE);
  assign req0   = en[0] & in0_valid & good0;
  assign req1   = en[1] & in1_valid & good1;
  assign drain0 = en[0] & in0_valid & ~good0;
  assign drain1 = en[1] & in1_valid & ~good1;

  assign sop_g   = gnt ? in1_sop   : in0_sop;
  assign valid_g = gnt ? in1_valid : in0_valid;
  assign data_g  = gnt ? in1_data  : in0_data;

  // A sop after the first byte means the current packet was short: leave the
  // sop unconsumed so it is re-arbitrated from IDLE.
  assign early_sop = sop_g & (cnt != '0);
  assign xfer_hs   = ~idle & valid_g & ~early_sop;
  assign abort_pkt = ~idle & valid_g & early_sop;

  assign in0_ready = idle ? drain0 : (~gnt & ~early_sop);
  assign in1_ready = idle ? drain1 : ( gnt & ~early_sop);

  // Both sources may drain a bad sop in the same cycle.
  assign bad_cnt  = {1'b0, idle & drain0 & in0_sop} + {1'b0, idle & drain1 & in1_sop};
  assign sync_sum = {1'b0, sync_err} + {7'd0, bad_cnt};

  assign grant    = idle & (req0 | req1) & ~out_almost_full;
  assign gnt_next = (req0 & req1) ? ~last : req1;

  assign busy = (state == ST_XFER);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      gnt       <= 1'b0;
      out_data  <= 8'd0;
      out_wrreq <= 1'b0;
      pkt_cnt0  <= 16'd0;
      pkt_cnt1  <= 16'd0;
      sync_err  <= 8'd0;
      short_err <= 8'd0;
    end else begin
      out_wrreq <= xfer_hs;
      if (xfer_hs) begin
        out_data <= data_g;
      end

      sync_err <= sync_sum[8] ? 8'hFF : sync_sum[7:0];

      case (state)
        ST_IDLE: begin
          if (grant) begin
            gnt   <= gnt_next;
            cnt   <= '0;
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (abort_pkt) begin
            if (short_err != 8'hFF) begin
              short_err <= short_err + 8'd1;
            end
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (xfer_hs) begin
            if (cnt == CNT_LAST) begin
              if (gnt) begin
                pkt_cnt1 <= pkt_cnt1 + 16'd1;
              end else begin
                pkt_cnt0 <= pkt_cnt0 + 16'd1;
              end
              last  <= gnt;
              cnt   <= '0;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ts_pkt_arbiter.md
Name: ts_pkt_arbiter

Overview:
- Packet-granular, round-robin arbiter that merges two TS byte sources into the single TS FIFO write port. Sources are, for example, filtered demod output and CAM return stream, or USB bulk stream and TSGEN.
- Switches source only on 188-byte packet boundaries and validates the sync byte.
- Drops misaligned bytes and aborts short packets.
- Exports per-source packet counters and error counters for the status registers.

Parameters:
PKT_LEN, 188, bytes per TS packet
SYNC_BYTE, 8'h47, required value of first packet byte

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
en  in  2  per-source enable, sampled only at grant
in0_data  in  8  source 0 byte
in0_valid  in  1  source 0 byte present
in0_sop  in  1  source 0 byte is first of packet
in0_ready  out  1  source 0 byte consumed this cycle (combinational)
in1_data  in  8  source 1 byte
in1_valid  in  1  source 1 byte present
in1_sop  in  1  source 1 byte is first of packet
in1_ready  out  1  source 1 byte consumed this cycle (combinational)
out_data  out  8  byte to TS FIFO (registered)
out_wrreq  out  1  TS FIFO write strobe (registered)
out_almost_full  in  1  TS FIFO almost full; threshold leaves at least PKT_LEN free
gnt  out  1  currently or last granted source
busy  out  1  high in XFER
pkt_cnt0  out  16  packets forwarded from source 0, wrapping
pkt_cnt1  out  16  packets forwarded from source 1, wrapping
sync_err  out  8  sop bytes not equal to SYNC_BYTE, saturating at 255
short_err  out  8  packets aborted by early sop, saturating at 255

Behaviour:
- Reset values: every output register is 0; state IDLE; byte counter 0; last pointer 1, so source 0 wins the first tie. Reset mid-packet abandons the packet immediately, with no partial flush.
- Handshake: a byte transfers in any cycle where inN_valid and inN_ready are both high.
- State IDLE:
  - ready_i = en[i] & valid_i & (~sop_i | data_i != SYNC_BYTE). This drains misaligned bytes and discards them.
  - Every consumed sop byte with a bad sync value increments sync_err.
  - req_i = en[i] & valid_i & sop_i & (data_i == SYNC_BYTE).
  - If any req_i is asserted and out_almost_full = 0: grant goes to the requester; if both request, it goes to the source != last. The state moves to XFER and gnt is updated. The sop byte is not consumed in the grant cycle.
  - If out_almost_full = 1, no grant is made and draining continues.
- State XFER:
  - ready_gnt = ~(sop_gnt & cnt != 0). The non-granted source has ready = 0.
  - On each handshake: out_data <= data, out_wrreq <= 1 on the next cycle, cnt += 1.
  - On a handshake with cnt == PKT_LEN-1: pkt_cnt[gnt] += 1, last <= gnt, cnt <= 0, state goes to IDLE.
  - If sop_gnt & valid_gnt & cnt != 0: the byte is not consumed, short_err += 1, cnt <= 0, state goes to IDLE. The new sop is re-arbitrated normally. Bytes already written stay in the FIFO.
  - out_almost_full is ignored during XFER, because the threshold guarantees room.
  - en deassertion during XFER has no effect; the packet completes.
- out_wrreq is 0 in every cycle without a handshake on the previous cycle.
- Timing: latency is 1 cycle from input handshake to out_wrreq. There is one idle bubble per packet, so at most 188 bytes per 189 cycles.
- Counter rules: pkt_cnt wraps from 0xFFFF to 0. The error counters hold at 8'hFF.

Test Plan:
- Reset, then source 0 streams 3 packets (47 01 77 ..., no gaps), en=2'b01 -> 564 out_wrreq pulses, data matches in order, pkt_cnt0=3, out_wrreq first rises 2 cycles after the first sop is presented.
- Both sources continuously valid, en=2'b11 -> grant order 0,1,0,1, no interleaving inside a packet, pkt_cnt0=pkt_cnt1=2 after 4 packets.
- Source 0 presents 5 junk bytes then sop byte 8'h48, then a valid packet -> all junk and the 8'h48 drained with no out_wrreq, sync_err=1, the following packet forwarded intact.
- Source 1 sends 100 bytes then a new sop with 8'h47 -> 100 bytes written, short_err=1, state returns to IDLE, the next packet is forwarded with full 188 bytes.
- out_almost_full=1 while sop is valid -> ready low, no grant for 50 cycles; deassert -> grant in 1 cycle. Asserting out_almost_full at byte 90 of a packet does not stall it.
- Assert reset at byte 120 -> next cycle out_wrreq=0, all counters 0, busy=0; the restarted stream forwards correctly from its next sop.
